overflow_logger_rr: RTL and testbench

- Parametrised successor to the 24-channel overflow deadtime FIFO controller.
- Collects (start LTC, end LTC, channel) overflow records from N waveform-acquisition channels over a req/ack four-phase handshake and stores them in an internal FWFT FIFO read by xdom.
- New versus the previous generation:
  - single-cycle rotating-priority grant instead of one-channel-per-two-cycle polling;
  - parametrised depth and index width;
  - almost-full flag;
  - optional drop-on-full mode with a saturating drop counter.

---
 rtl/overflow_logger_rr_pkg.sv | 21 ++
 rtl/overflow_logger_rr_sync_fwft_fifo.sv | 62 ++++++
 rtl/overflow_logger_rr.sv | 157 +++++++++++++++
 tb/tb_overflow_logger_rr.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overflow_logger_rr_pkg.sv
// Shared types and width helpers for the overflow logger.
package overflow_logger_rr_pkg;

  typedef enum logic [1:0] {
    S_SCAN    = 2'd0,
    S_CAPTURE = 2'd1,
    S_WRITE   = 2'd2,
    S_ACK     = 2'd3
  } state_e;

  // Channel index width; a single-bit index is kept even for tiny N.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy width; one extra bit so DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/overflow_logger_rr_sync_fwft_fifo.sv
// First-word-fall-through FIFO: RAM array plus a registered head word.
module sync_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign do_wr    = wr_en_i && !full_o;
  assign do_rd    = rd_en_i && !empty_o;
  assign rd_ptr_d = rd_ptr_q + AW'(do_rd);
  assign head_o   = head_q;
  assign count_o  = count_q;

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head register: bypass the write when it lands in the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              head_q <= '0;
    else if (do_wr && wr_ptr_q == rd_ptr_d)  head_q <= wdata_i;
    else if (do_wr || do_rd)                 head_q <= mem_q[rd_ptr_d];
  end

  // Pointers and occupancy; simultaneous read and write leave count as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/overflow_logger_rr.sv
// Overflow record logger: rotating-priority grant over N channels,
// four-phase req/ack, records stored in an FWFT FIFO.
module overflow_logger_rr import overflow_logger_rr_pkg::*; #(
  parameter  int N_CHANNELS     = 24,
  parameter  int P_LTC_WIDTH    = 48,
  parameter  int FIFO_DEPTH     = 256,
  parameter  int AF_THRESH      = 224,
  parameter  int DROP_ON_FULL   = 0,
  parameter  int DROP_CNT_WIDTH = 16,
  localparam int IDX_W          = idx_width(N_CHANNELS),
  localparam int CNT_W          = cnt_width(FIFO_DEPTH),
  localparam int REC_W          = 2 * P_LTC_WIDTH + IDX_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_CHANNELS-1:0]             req,
  input  logic [N_CHANNELS*P_LTC_WIDTH-1:0] overflow_start_ltc,
  input  logic [N_CHANNELS*P_LTC_WIDTH-1:0] overflow_end_ltc,
  output logic [N_CHANNELS-1:0]             ack,
  input  logic                              rd_req,
  input  logic                              drop_clr,
  output logic [CNT_W-1:0]                  overflow_fifo_count,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic                              almost_full,
  output logic [P_LTC_WIDTH-1:0]            overflow_start_ltc_out,
  output logic [P_LTC_WIDTH-1:0]            overflow_end_ltc_out,
  output logic [IDX_W-1:0]                  channel_index_out,
  output logic [DROP_CNT_WIDTH-1:0]         drop_count
);
  localparam logic [IDX_W:0]       N_L  = (IDX_W+1)'(N_CHANNELS);
  localparam logic [CNT_W-1:0]     AF_L = CNT_W'(AF_THRESH);

  state_e                    state_q, state_d;
  logic [N_CHANNELS-1:0]     req_q, ack_q, ack_d, rot;
  logic [IDX_W-1:0]          sel_q, sel_d, ptr_q, ptr_d, gnt, off;
  logic [IDX_W:0]            sum, sel_p1;
  logic                      hit, wr_en, drop_inc;
  logic [P_LTC_WIDTH-1:0]    start_q, start_d, end_q, end_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [REC_W-1:0]          head;

  // Rotating priority: rotate req_q so ptr sits at bit 0, take lowest set bit.
  always_comb begin
    rot = N_CHANNELS'({req_q, req_q} >> ptr_q);
    hit = 1'b0;
    off = '0;
    for (int k = N_CHANNELS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        off = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    gnt = (sum >= N_L) ? IDX_W'(sum - N_L) : sum[IDX_W-1:0];
  end

  assign sel_p1 = {1'b0, sel_q} + (IDX_W+1)'(1);

  // Handshake FSM: scan, capture muxed LTCs, write, then hold ack until req drops.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    start_d  = start_q;
    end_d    = end_q;
    wr_en    = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (hit) begin
          if (!fifo_full) begin
            sel_d   = gnt;
            state_d = S_CAPTURE;
          end else if (DROP_ON_FULL != 0) begin
            sel_d    = gnt;
            drop_inc = 1'b1;
            state_d  = S_ACK;
          end
        end
      end
      S_CAPTURE: begin
        start_d = overflow_start_ltc[sel_q*P_LTC_WIDTH +: P_LTC_WIDTH];
        end_d   = overflow_end_ltc[sel_q*P_LTC_WIDTH +: P_LTC_WIDTH];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!req_q[sel_q]) begin
          ptr_d   = (sel_p1 == N_L) ? '0 : sel_p1[IDX_W-1:0];
          state_d = S_SCAN;
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  // Ack is registered and follows the state we are entering.
  always_comb begin
    ack_d = '0;
    if (state_d == S_ACK) ack_d[sel_d] = 1'b1;
  end

  // Drop counter: clear wins but a coincident drop still counts as one.
  always_comb begin
    drop_d = drop_q;
    if (drop_clr)                     drop_d = drop_inc ? DROP_CNT_WIDTH'(1) : '0;
    else if (drop_inc && drop_q != '1) drop_d = drop_q + DROP_CNT_WIDTH'(1);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SCAN;
      req_q   <= '0;
      ack_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      end_q   <= end_d;
      drop_q  <= drop_d;
    end
  end

  sync_fwft_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (wr_en),
    .wdata_i ({start_q, end_q, sel_q}),
    .rd_en_i (rd_req),
    .head_o  (head),
    .count_o (overflow_fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {overflow_start_ltc_out, overflow_end_ltc_out, channel_index_out} = head;
  assign almost_full = (overflow_fifo_count >= AF_L);
  assign ack         = ack_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_overflow_logger_rr.sv
// Bench for overflow_logger_rr: a stall-mode and a drop-mode instance
// (depth 4, almost-full at 3); popped records checked against a queue.
module tb_overflow_logger_rr;
  localparam int N  = 24;
  localparam int W  = 48;
  localparam int IW = 5;
  localparam int CW = 3;
  localparam int DC = 16;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [W-1:0]  e;
    logic [IW-1:0] c;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]  req [2];
  logic [N-1:0]  ack [2];
  logic          rd [2], dclr [2], full [2], empty [2], af [2];
  logic [CW-1:0] cnt [2];
  logic [W-1:0]  hs [2], he [2];
  logic [IW-1:0] hidx [2];
  logic [DC-1:0] dcnt [2];
  logic [W-1:0]  st [N], en [N];
  logic [N*W-1:0] st_pk, en_pk;

  int ntests = 0;
  int nfail  = 0;
  rec_t q0[$], q1[$];

  always #5 clk = ~clk;

  always_comb begin
    st_pk = '0;
    en_pk = '0;
    for (int c = 0; c < N; c++) begin
      st_pk[c*W +: W] = st[c];
      en_pk[c*W +: W] = en[c];
    end
  end

  overflow_logger_rr #(.N_CHANNELS(N), .P_LTC_WIDTH(W), .FIFO_DEPTH(4), .AF_THRESH(3),
                       .DROP_ON_FULL(0), .DROP_CNT_WIDTH(DC)) u_stall (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .overflow_start_ltc(st_pk),
    .overflow_end_ltc(en_pk), .ack(ack[0]), .rd_req(rd[0]), .drop_clr(dclr[0]),
    .overflow_fifo_count(cnt[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
    .almost_full(af[0]), .overflow_start_ltc_out(hs[0]), .overflow_end_ltc_out(he[0]),
    .channel_index_out(hidx[0]), .drop_count(dcnt[0]));

  overflow_logger_rr #(.N_CHANNELS(N), .P_LTC_WIDTH(W), .FIFO_DEPTH(4), .AF_THRESH(3),
                       .DROP_ON_FULL(1), .DROP_CNT_WIDTH(DC)) u_drop (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .overflow_start_ltc(st_pk),
    .overflow_end_ltc(en_pk), .ack(ack[1]), .rd_req(rd[1]), .drop_clr(dclr[1]),
    .overflow_fifo_count(cnt[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
    .almost_full(af[1]), .overflow_start_ltc_out(hs[1]), .overflow_end_ltc_out(he[1]),
    .channel_index_out(hidx[1]), .drop_count(dcnt[1]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rec_t exp_rec(input int c);
    return {st[c], en[c], IW'(c)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int d, input int c, input logic val, input int budget);
    int n = 0;
    while (ack[d][c] !== val && n < budget) begin
      tick;
      n++;
    end
    chk($sformatf("ack%0b d%0d ch%0d", val, d, c), 128'(ack[d][c]), 128'(val));
  endtask

  task automatic hs_one(input int d, input int c);
    req[d][c] = 1'b1;
    wait_ack(d, c, 1'b1, 20);
    req[d][c] = 1'b0;
    wait_ack(d, c, 1'b0, 20);
  endtask

  task automatic pop(input int d);
    rd[d] = 1'b1;
    tick;
    rd[d] = 1'b0;
  endtask

  task automatic serve(input int d, input int budget, output int left);
    int n = 0;
    while ((req[d] != '0 || ack[d] != '0) && n < budget) begin
      tick;
      n++;
      for (int c = 0; c < N; c++)
        if (ack[d][c] && req[d][c]) req[d][c] = 1'b0;
    end
    left = $countones(req[d]);
  endtask

  // Monitor: each accepted pop is compared against the next expected record.
  task automatic mon(input int d);
    rec_t a, e;
    a = {hs[d], he[d], hidx[d]};
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      ntests++;
      nfail++;
      $display("FAIL pop d%0d: got record %0h, none expected", d, a);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("head d%0d", d), 128'(a), 128'(e));
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rst_n && rd[d] && !empty[d]) mon(d);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int left;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; rd[d] = 1'b0; dclr[d] = 1'b0;
    end
    for (int c = 0; c < N; c++) begin
      st[c] = 48'hA000_0000_0000 + 48'(c * 256);
      en[c] = 48'hB000_0000_0000 + 48'(c * 256 + 15);
    end
    st[5] = 48'h100;
    en[5] = 48'h1F0;

    // Reset state
    repeat (3) tick;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst ack d%0d", d),   128'(ack[d]),   128'(0));
      chk($sformatf("rst cnt d%0d", d),   128'(cnt[d]),   128'(0));
      chk($sformatf("rst empty d%0d", d), 128'(empty[d]), 128'(1));
      chk($sformatf("rst full d%0d", d),  128'(full[d]),  128'(0));
      chk($sformatf("rst af d%0d", d),    128'(af[d]),    128'(0));
      chk($sformatf("rst head d%0d", d),  128'({hs[d], he[d], hidx[d]}), 128'(0));
      chk($sformatf("rst drop d%0d", d),  128'(dcnt[d]),  128'(0));
    end
    rst_n = 1'b1;
    tick;

    // Single request, latency 4
    req[0][5] = 1'b1;
    repeat (3) tick;
    chk("single ack early", 128'(ack[0]), 128'(0));
    tick;
    chk("single ack c4", 128'(ack[0]), 128'(24'h00_0020));
    chk("single cnt", 128'(cnt[0]), 128'(1));
    chk("single head", 128'({hs[0], he[0], hidx[0]}), 128'({48'h100, 48'h1F0, 5'd5}));
    req[0][5] = 1'b0;
    tick;
    chk("single ack hold", 128'(ack[0]), 128'(24'h00_0020));
    tick;
    chk("single ack drop", 128'(ack[0]), 128'(0));
    q0.push_back(exp_rec(5));
    pop(0);
    chk("single empty", 128'(empty[0]), 128'(1));

    // Round robin from ptr 0
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    req[0][0] = 1'b1; req[0][3] = 1'b1; req[0][23] = 1'b1;
    q0.push_back(exp_rec(0)); q0.push_back(exp_rec(3)); q0.push_back(exp_rec(23));
    serve(0, 100, left);
    chk("rr1 left", 128'(left), 128'(0));
    chk("rr1 cnt", 128'(cnt[0]), 128'(3));
    repeat (3) pop(0);
    hs_one(0, 0);
    q0.push_back(exp_rec(0));
    pop(0);
    // ptr now 1
    req[0][0] = 1'b1; req[0][3] = 1'b1; req[0][23] = 1'b1;
    q0.push_back(exp_rec(3)); q0.push_back(exp_rec(23)); q0.push_back(exp_rec(0));
    serve(0, 100, left);
    chk("rr2 left", 128'(left), 128'(0));
    repeat (3) pop(0);

    // Stall mode: five requests into depth 4
    for (int c = 10; c < 15; c++) begin
      req[0][c] = 1'b1;
      q0.push_back(exp_rec(c));
    end
    serve(0, 60, left);
    chk("stall left", 128'(left), 128'(1));
    chk("stall cnt", 128'(cnt[0]), 128'(4));
    chk("stall full", 128'(full[0]), 128'(1));
    chk("stall af", 128'(af[0]), 128'(1));
    chk("stall ack", 128'(ack[0]), 128'(0));
    pop(0);
    serve(0, 40, left);
    chk("stall left2", 128'(left), 128'(0));
    chk("stall cnt2", 128'(cnt[0]), 128'(4));
    chk("stall full2", 128'(full[0]), 128'(1));
    pop(0);
    chk("af cnt3", 128'(af[0]), 128'(1));
    pop(0);
    chk("af cnt2", 128'(af[0]), 128'(0));
    repeat (2) pop(0);
    chk("stall empty", 128'(empty[0]), 128'(1));

    // Almost-full rising edge
    hs_one(0, 1);
    chk("af w1", 128'(af[0]), 128'(0));
    hs_one(0, 2);
    chk("af w2", 128'(af[0]), 128'(0));
    hs_one(0, 3);
    chk("af w3", 128'(af[0]), 128'(1));
    chk("af w3 cnt", 128'(cnt[0]), 128'(3));
    q0.push_back(exp_rec(1)); q0.push_back(exp_rec(2)); q0.push_back(exp_rec(3));
    repeat (3) pop(0);

    // Drop mode
    hs_one(1, 4); hs_one(1, 5); hs_one(1, 6); hs_one(1, 8);
    q1.push_back(exp_rec(4)); q1.push_back(exp_rec(5));
    q1.push_back(exp_rec(6)); q1.push_back(exp_rec(8));
    chk("drop fill cnt", 128'(cnt[1]), 128'(4));
    chk("drop fill full", 128'(full[1]), 128'(1));
    chk("drop fill dcnt", 128'(dcnt[1]), 128'(0));
    hs_one(1, 2);
    chk("drop cnt", 128'(cnt[1]), 128'(4));
    chk("drop dcnt", 128'(dcnt[1]), 128'(1));
    req[1][2] = 1'b1;
    tick;
    dclr[1] = 1'b1;
    tick;
    dclr[1] = 1'b0;
    chk("drop clr+inc", 128'(dcnt[1]), 128'(1));
    chk("drop clr ack", 128'(ack[1]), 128'(24'h00_0004));
    req[1][2] = 1'b0;
    wait_ack(1, 2, 1'b0, 20);
    repeat (4) pop(1);
    chk("drop empty", 128'(empty[1]), 128'(1));

    // Asynchronous reset in S_ACK
    req[0][7] = 1'b1;
    wait_ack(0, 7, 1'b1, 20);
    chk("arst pre cnt", 128'(cnt[0]), 128'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("arst ack", 128'(ack[0]), 128'(0));
    chk("arst cnt", 128'(cnt[0]), 128'(0));
    chk("arst empty", 128'(empty[0]), 128'(1));
    chk("arst dcnt", 128'(dcnt[1]), 128'(0));
    chk("arst head", 128'(hs[0]), 128'(0));
    tick;
    rst_n = 1'b1;
    wait_ack(0, 7, 1'b1, 20);
    chk("arst recap cnt", 128'(cnt[0]), 128'(1));
    q0.push_back(exp_rec(7));
    pop(0);
    req[0][7] = 1'b0;
    wait_ack(0, 7, 1'b0, 20);
    chk("q0 drained", 128'(q0.size()), 128'(0));
    chk("q1 drained", 128'(q1.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
